// File: rtl/pingpong_pkg.sv
// Shared constants for the ping-pong scoreboard: score range, segment patterns, digit enables.
// Purely declarative; no logic, no latency, no flow control.
package pingpong_pkg;

    localparam logic [2:0] MAX_SCORE = 3'd7;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_OFF     = 4'b1111;
    localparam logic [3:0] CODE_DASH  = 4'd8;
    localparam logic [3:0] CODE_BLANK = 4'd9;

    // Scan slot numbering matches AN bit position; slot 3 is the leftmost digit.
    typedef enum logic [1:0] {
        SLOT_P2     = 2'd0,
        SLOT_DASH_R = 2'd1,
        SLOT_DASH_L = 2'd2,
        SLOT_P1     = 2'd3
    } slot_e;

    function automatic logic [3:0] an_for_slot(input logic [1:0] slot);
        return ~(4'b0001 << slot);
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Seven-segment decoder: codes 0-7 digits, 8 dash, anything else blank (active-low).
// Combinational, zero latency; no flow control.
module seg7_decode
    import pingpong_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (code)
            4'd0:      seg = SEG_0;
            4'd1:      seg = SEG_1;
            4'd2:      seg = SEG_2;
            4'd3:      seg = SEG_3;
            4'd4:      seg = SEG_4;
            4'd5:      seg = SEG_5;
            4'd6:      seg = SEG_6;
            4'd7:      seg = SEG_7;
            CODE_DASH: seg = SEG_DASH;
            default:   seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/pingpong_scoreboard.sv
// Four-digit multiplexed scoreboard "S1 - - S2"; scores latched only at frame end. Winner blink: SCOREBOARD_WINNER_BLINK_EN.
// AN/SEG/FRAME registered, one cycle behind scan state; each digit held REFRESH_DIV cycles.
// No backpressure: free-running scan, score inputs sampled once per frame.
module pingpong_scoreboard
    import pingpong_pkg::*;
#(
    parameter int REFRESH_DIV  = 250,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [2:0] Score1,
    input  logic [2:0] Score2,
    output logic [3:0] AN,
    output logic [6:0] SEG,
    output logic       FRAME
);

    localparam int RC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(REFRESH_DIV - 1);

    if (REFRESH_DIV < 2 || BLINK_FRAMES < 1) begin : g_param_check
        $error("pingpong_scoreboard: REFRESH_DIV must be >= 2 and BLINK_FRAMES >= 1");
    end

    logic [RC_W-1:0] rc;
    slot_e           idx;
    logic [2:0]      disp1;
    logic [2:0]      disp2;
    logic            slot_end;
    logic            frame_end;
    logic            blink_phase;
    logic [3:0]      digit_code;
    logic [6:0]      seg_nxt;

    assign slot_end  = (rc == RC_LAST);
    assign frame_end = slot_end && (idx == SLOT_P2);

    always_ff @(posedge CLK) begin
        if (RST) begin
            rc    <= '0;
            idx   <= SLOT_P1;
            disp1 <= 3'd0;
            disp2 <= 3'd0;
        end else begin
            if (slot_end) begin
                rc  <= '0;
                idx <= slot_e'(idx - 2'd1);
            end else begin
                rc  <= rc + 1'b1;
            end
            // Latch only at the frame boundary so a digit never changes mid-scan.
            if (frame_end) begin
                disp1 <= Score1;
                disp2 <= Score2;
            end
        end
    end

`ifdef SCOREBOARD_WINNER_BLINK_EN
    localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

    logic [FC_W-1:0] fc;
    logic            blink;

    always_ff @(posedge CLK) begin
        if (RST) begin
            fc    <= '0;
            blink <= 1'b0;
        end else if (frame_end) begin
            if (fc == FC_LAST) begin
                fc    <= '0;
                blink <= ~blink;
            end else begin
                fc    <= fc + 1'b1;
            end
        end
    end

    assign blink_phase = blink;
`else
    assign blink_phase = 1'b0;
`endif

    always_comb begin
        digit_code = CODE_DASH;
        case (idx)
            SLOT_P1: digit_code = (blink_phase && disp1 == MAX_SCORE) ? CODE_BLANK : {1'b0, disp1};
            SLOT_P2: digit_code = (blink_phase && disp2 == MAX_SCORE) ? CODE_BLANK : {1'b0, disp2};
            default: digit_code = CODE_DASH;
        endcase
    end

    seg7_decode u_decode (
        .code (digit_code),
        .seg  (seg_nxt)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            AN    <= AN_OFF;
            SEG   <= SEG_BLANK;
            FRAME <= 1'b0;
        end else begin
            AN    <= an_for_slot(idx);
            SEG   <= seg_nxt;
            FRAME <= frame_end;
        end
    end

endmodule

// File: tb/tb_pingpong_scoreboard.sv
// Scoreboard bench for pingpong_scoreboard (REFRESH_DIV=4, BLINK_FRAMES=2): expected AN/SEG/FRAME queued per cycle, checked at negedge.
module tb_pingpong_scoreboard;

    localparam logic [6:0] P_0     = 7'b1000000;
    localparam logic [6:0] P_2     = 7'b0100100;
    localparam logic [6:0] P_3     = 7'b0110000;
    localparam logic [6:0] P_7     = 7'b1111000;
    localparam logic [6:0] P_DASH  = 7'b0111111;
    localparam logic [6:0] P_BLANK = 7'b1111111;

`ifdef SCOREBOARD_WINNER_BLINK_EN
    localparam bit BLINK_BUILD = 1'b1;
`else
    localparam bit BLINK_BUILD = 1'b0;
`endif

    typedef struct {
        int         at;
        logic [3:0] an;
        logic [6:0] seg;
        logic       frame;
        string      name;
    } exp_t;

    logic       CLK;
    logic       RST;
    logic [2:0] Score1;
    logic [2:0] Score2;
    logic [3:0] AN;
    logic [6:0] SEG;
    logic       FRAME;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    pingpong_scoreboard #(
        .REFRESH_DIV  (4),
        .BLINK_FRAMES (2)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .Score1 (Score1),
        .Score2 (Score2),
        .AN     (AN),
        .SEG    (SEG),
        .FRAME  (FRAME)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Monitor: pops every expectation due at this cycle and compares.
    always @(negedge CLK) begin
        while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (mon_e.at != cyc || AN !== mon_e.an || SEG !== mon_e.seg || FRAME !== mon_e.frame) begin
                failures++;
                $display("FAIL %s cyc=%0d due=%0d: got AN=%b SEG=%b FRAME=%b, want AN=%b SEG=%b FRAME=%b",
                         mon_e.name, cyc, mon_e.at, AN, SEG, FRAME, mon_e.an, mon_e.seg, mon_e.frame);
            end
        end
    end

    task automatic push_one(input int at, input logic [3:0] an, input logic [6:0] seg,
                            input logic frame, input string name);
        exp_t e;
        e.at    = at;
        e.an    = an;
        e.seg   = seg;
        e.frame = frame;
        e.name  = name;
        exp_q.push_back(e);
    endtask

    // k counts edges since reset release; digit slot changes every 4 edges, frame every 16.
    task automatic push_range(input int b, input int lo, input int hi, input logic [6:0] s3,
                              input logic [6:0] s0, input bit blink, input string name);
        logic [3:0] an;
        logic [6:0] seg;
        for (int k = lo; k <= hi; k++) begin
            case ((k / 4) % 4)
                0:       begin an = 4'b0111; seg = s3;     end
                1:       begin an = 4'b1011; seg = P_DASH; end
                2:       begin an = 4'b1101; seg = P_DASH; end
                default: begin an = 4'b1110; seg = s0;     end
            endcase
            if (blink && seg == P_7 && ((k / 32) % 2 == 1))
                seg = P_BLANK;
            push_one(b + k, an, seg, (k % 16 == 15), name);
        end
    endtask

    task automatic wait_k(input int b, input int k);
        while (cyc < b + k) begin
            @(posedge CLK);
            #1;
        end
    endtask

    int base;
    int base2;

    initial begin
        RST    = 1'b1;
        Score1 = 3'd0;
        Score2 = 3'd0;
        for (int c = 1; c <= 3; c++)
            push_one(c, 4'b1111, P_BLANK, 1'b0, "reset_hold");

        repeat (3) begin
            @(posedge CLK);
            #1;
        end
        RST  = 1'b0;
        base = cyc + 1;

        push_range(base, 0, 31, P_0, P_0, 1'b0, "scan_zero");
        push_range(base, 32, 47, P_3, P_0, 1'b0, "latch_s1_glitch_s2");
        push_range(base, 48, 73, P_3, P_2, 1'b0, "latch_s2");
        push_one(base + 74, 4'b1111, P_BLANK, 1'b0, "midscan_reset");

        wait_k(base, 17);
        Score1 = 3'd3;
        wait_k(base, 21);
        Score2 = 3'd5;
        wait_k(base, 25);
        Score2 = 3'd0;
        wait_k(base, 40);
        Score2 = 3'd2;
        wait_k(base, 73);
        RST = 1'b1;
        wait_k(base, 74);
        RST   = 1'b0;
        base2 = cyc + 1;

        push_range(base2, 0, 15, P_0, P_0, 1'b0, "restart_cleared");
        push_range(base2, 16, 215, P_7, P_7, BLINK_BUILD, BLINK_BUILD ? "winner_blink" : "winner_steady");

        wait_k(base2, 0);
        Score1 = 3'd7;
        Score2 = 3'd7;
        wait_k(base2, 217);
        repeat (2) @(posedge CLK);
        #1;

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pingpong_scoreboard.md
# pingpong_scoreboard

Multiplexed four-digit seven-segment scoreboard for the ping-pong game, directly downstream of the game FSM. Consumes its `Score1`/`Score2` outputs. Shows `Score1`, a dash, a dash and `Score2` on a common-anode display. Scores are latched only at frame boundaries so no digit tears mid-scan, and a winning score (7) optionally blinks.

## Interface
- `REFRESH_DIV`, default 250: CLK cycles each digit stays enabled; must be ≥2.
- `BLINK_FRAMES`, default 64: full scan frames per blink-phase toggle; must be ≥1.
- `CLK`  in  1  system clock; all logic on its rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `Score1`  in  3  player-1 score from game FSM, 0–7.
- `Score2`  in  3  player-2 score from game FSM, 0–7.
- `AN`  out  4  digit enables, active-low; `AN[3]` is leftmost.
- `SEG`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `FRAME`  out  1  one-cycle pulse marking the score-latch edge.

## Operation
- Scan index `idx`, 2-bit: order 3→2→1→0→3, wraps.
- Digit content by slot:
  - idx 3: `disp1`
  - idx 2: dash
  - idx 1: dash
  - idx 0: `disp2`
- Refresh counter `rc` (0..REFRESH_DIV-1):
  - Increments every cycle.
  - At `rc==REFRESH_DIV-1`: `rc←0` and `idx←idx-1` (mod 4).
- Frame end is `rc==REFRESH_DIV-1 && idx==0`. On that edge:
  - `disp1←Score1`, `disp2←Score2`.
  - `FRAME←1` for one cycle.
  - Frame counter `fc` increments; at `fc==BLINK_FRAMES-1`, `fc←0` and `blink←~blink`.
- Score changes between frame ends are invisible until the next frame end.
- Glitches on `Score1`/`Score2` shorter than a frame are never displayed unless present at the latch edge.
- Decode (active-low gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - dash=0111111
- Both scores 7 simultaneously: both score digits blink in phase.
- Reset values:
  - `AN=1111`, `SEG=1111111`, `FRAME=0`
  - `idx=3`, `rc=0`, `fc=0`, `blink=0`
  - `disp1=disp2=0`
- `RST` asserted mid-operation: the next edge forces all reset values regardless of state; no partial frame completes.

## Timing
- `AN`, `SEG` and `FRAME` are registered and computed from the current `idx`/`disp`/`blink`. They lag internal state by one cycle.
- First cycle after `RST` deasserts: `AN=1111`. One cycle later: `AN=0111`, `SEG=1000000`.
- Each `AN` value is held exactly `REFRESH_DIV` cycles. One frame = 4×`REFRESH_DIV` cycles.
- Latched score first appears on the `AN=0111` slot immediately following the `FRAME` pulse.
- Blink half-period = `BLINK_FRAMES` × 4 × `REFRESH_DIV` cycles.

## Configuration
- `SCOREBOARD_WINNER_BLINK_EN` defined:
  - A score digit whose latched value is 7 shows `SEG=1111111` while `blink=1`, and normal decode while `blink=0`.
  - `AN` stays asserted during the blanked phase.
- Not defined:
  - `fc`/`blink` logic is removed.
  - 7 displays steadily; `FRAME` is unaffected.

## Structure
- Shared package `pingpong_pkg`:
  - `MAX_SCORE=3'd7`
  - seven-seg pattern constants `SEG_0`..`SEG_7` and `SEG_DASH`, `SEG_BLANK`
  - `AN_OFF=4'b1111`
- Sub-module `seg7_decode`: purely combinational; 4-bit code in, 7-bit active-low segments out; code 8 = dash, 9 = blank.
- Top-level holds the counters, scan index, latches and output registers.

## Test plan
Bench uses REFRESH_DIV=4, BLINK_FRAMES=2, so a frame is 16 cycles.
- Reset: hold `RST` 3 cycles → `AN=1111`, `SEG=1111111`, `FRAME=0`; one cycle after release + 1 → `AN=0111`, `SEG=1000000`.
- Scan: scores 0/0 → `AN` cycles 0111, 1011, 1101, 1110, each for 4 cycles, then wraps. Dash slots show `SEG=0111111`. `FRAME` pulses every 16 cycles.
- Latch: set `Score1=3` at cycle 5 of a frame → digit 3 stays 1000000 until after the `FRAME` pulse, then shows 0110000.
- Blink with macro: `Score2=7` → digit 0 alternates 1111000 and 1111111, with a 32-cycle half-period.
- No macro: `Score1=7`, `Score2=7` → both digits steady at 1111000 for 200 cycles.
- Mid-scan reset: assert `RST` while `AN=1101` → next cycle `AN=1111`, `disp1`/`disp2` cleared, and scan restarts at idx 3.
